// File: rtl/easy_fifo_pkg.sv
// Shared helpers for the FIFO read-side adapter: latency limit, counter
// widths and pointer wrap for buffers whose depth is not a power of two.
package easy_fifo_pkg;

   localparam int RD_LATENCY_MAX = 2;

   // Bits needed to hold a count in the range 0..n (at least one bit).
   function automatic int unsigned cnt_w(input int unsigned n);
      return (n < 1) ? 1 : $clog2(n + 1);
   endfunction

   // Advance a circular-buffer pointer, wrapping at an arbitrary depth.
   function automatic int unsigned ptr_inc(input int unsigned ptr, input int unsigned depth);
      return (ptr + 1 >= depth) ? 0 : ptr + 1;
   endfunction

endpackage

// File: rtl/fifo_rd2axis_buf.sv
// Small register-based circular buffer that absorbs the FIFO read latency.
// Head data is forced to zero while the buffer is empty so the stream output
// is clean after reset without needing to reset the storage itself.
module fifo_rd2axis_buf
   import easy_fifo_pkg::*;
#(
   parameter int DWIDTH = 32,
   parameter int DEPTH  = 3
) (
   input  logic                    clk_i,
   input  logic                    rst_n_i,
   input  logic                    wr_en_i,
   input  logic [DWIDTH-1:0]       wr_data_i,
   input  logic                    rd_en_i,
   output logic [cnt_w(DEPTH)-1:0] occ_o,
   output logic [DWIDTH-1:0]       head_o
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int OCC_W = cnt_w(DEPTH);

   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [OCC_W-1:0]  occ_q, occ_d;
   logic [DWIDTH-1:0] mem_q [DEPTH];
   logic              rd_fire;

   // Next-state for pointers and occupancy; a read only counts when data is held.
   always_comb begin
      rd_fire  = rd_en_i && (occ_q != '0);
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      occ_d    = occ_q;
      if (wr_en_i) wr_ptr_d = PTR_W'(ptr_inc(32'(wr_ptr_q), DEPTH));
      if (rd_fire) rd_ptr_d = PTR_W'(ptr_inc(32'(rd_ptr_q), DEPTH));
      case ({wr_en_i, rd_fire})
         2'b10:   occ_d = occ_q + OCC_W'(1);
         2'b01:   occ_d = occ_q - OCC_W'(1);
         default: occ_d = occ_q;
      endcase
   end

   // Control state register; storage contents are left unreset.
   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         occ_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         occ_q    <= occ_d;
      end
   end

   // Data storage write.
   always_ff @(posedge clk_i) begin
      if (wr_en_i) mem_q[wr_ptr_q] <= wr_data_i;
   end

   // Catch a write into a full buffer; upstream credit control must prevent it.
   always_ff @(posedge clk_i) begin
      if (rst_n_i && wr_en_i)
         assert (occ_q != OCC_W'(DEPTH)) else $error("fifo_rd2axis_buf: write while full");
   end

   assign occ_o  = occ_q;
   assign head_o = (occ_q != '0) ? mem_q[rd_ptr_q] : '0;

endmodule

// File: rtl/fifo_rd2axis.sv
// FIFO read port to AXI-Stream master. Pops are issued only when the skid
// buffer is guaranteed room for every outstanding read, which lets the
// stream run at one beat per cycle despite the FIFO read latency.
module fifo_rd2axis
   import easy_fifo_pkg::*;
#(
   parameter int DWIDTH     = 32,
   parameter int RD_LATENCY = 1,
   parameter int PKT_LEN    = 0
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic [DWIDTH-1:0]               fifo_rd_data,
   input  logic                            fifo_empty,
   output logic                            fifo_rd_en,
   output logic [DWIDTH-1:0]               m_axis_tdata,
   output logic                            m_axis_tvalid,
   input  logic                            m_axis_tready,
   output logic                            m_axis_tlast,
   output logic [$clog2(RD_LATENCY+3)-1:0] level
);

   localparam int BUF_DEPTH = RD_LATENCY + 2;
   localparam int OCC_W     = cnt_w(BUF_DEPTH);
   localparam int BEAT_W    = cnt_w(PKT_LEN);
   localparam int LAST_BEAT = (PKT_LEN > 0) ? PKT_LEN - 1 : 0;

   if (RD_LATENCY < 0 || RD_LATENCY > RD_LATENCY_MAX) begin : g_bad_latency
      $error("fifo_rd2axis: RD_LATENCY out of range");
   end

   logic [OCC_W-1:0]  occ;
   logic [OCC_W-1:0]  inflight;
   logic              buf_wr;
   logic              xfer;
   logic [BEAT_W-1:0] beat_cnt_q, beat_cnt_d;

   // Pop only if everything already buffered plus everything in flight still fits.
   always_comb begin
      fifo_rd_en = 1'b0;
      if (rst && !fifo_empty && (32'(occ) + 32'(inflight) < BUF_DEPTH))
         fifo_rd_en = 1'b1;
   end

   if (RD_LATENCY == 0) begin : g_fwft
      assign buf_wr   = fifo_rd_en;
      assign inflight = '0;
   end else begin : g_pipe
      logic [RD_LATENCY-1:0] vld_pipe_q, vld_pipe_d;

      // Delay the pop strobe so the buffer write lines up with valid FIFO data.
      always_comb vld_pipe_d = RD_LATENCY'({vld_pipe_q, fifo_rd_en});

      // In-flight valid pipe; cleared on reset so outstanding pops are dropped.
      always_ff @(posedge clk) begin
         if (!rst) vld_pipe_q <= '0;
         else      vld_pipe_q <= vld_pipe_d;
      end

      assign buf_wr   = vld_pipe_q[RD_LATENCY-1];
      assign inflight = OCC_W'($countones(vld_pipe_q));
   end

   fifo_rd2axis_buf #(
      .DWIDTH (DWIDTH),
      .DEPTH  (BUF_DEPTH)
   ) u_buf (
      .clk_i     (clk),
      .rst_n_i   (rst),
      .wr_en_i   (buf_wr),
      .wr_data_i (fifo_rd_data),
      .rd_en_i   (xfer),
      .occ_o     (occ),
      .head_o    (m_axis_tdata)
   );

   assign m_axis_tvalid = (occ != '0);
   assign xfer          = m_axis_tvalid && m_axis_tready;
   assign level         = occ;

   // Beat position within the packet; advances on each accepted beat.
   always_comb begin
      beat_cnt_d = beat_cnt_q;
      if (xfer && (PKT_LEN > 0)) begin
         if (beat_cnt_q == BEAT_W'(LAST_BEAT)) beat_cnt_d = '0;
         else                                  beat_cnt_d = beat_cnt_q + BEAT_W'(1);
      end
   end

   // Beat counter register.
   always_ff @(posedge clk) begin
      if (!rst) beat_cnt_q <= '0;
      else      beat_cnt_q <= beat_cnt_d;
   end

   assign m_axis_tlast = (PKT_LEN > 0) && m_axis_tvalid && (beat_cnt_q == BEAT_W'(LAST_BEAT));

endmodule

// File: tb/tb_fifo_rd2axis.sv
// Bench for fifo_rd2axis: three instances (read latency 0, 1 and 2) fed by a
// behavioural FIFO model, checked against sequence/scoreboard expectations.
module tb_fifo_rd2axis;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   logic [2:0]  rst_v = 3'b000;
   logic [2:0]  tready_v = 3'b000;
   logic [2:0]  empty_v, rd_en_v, tvalid_v, tlast_v;
   logic [31:0] rdata0, rdata1, rdata2;
   logic [31:0] tdata0, tdata1, tdata2;
   logic [1:0]  level0, level1;
   logic [2:0]  level2;

   // FIFO model: store/fill/force_empty owned by the stimulus, rdi/d1/d2 by the model.
   logic [31:0] store [3][1024];
   logic [9:0]  fill [3];
   logic [2:0]  force_empty = 3'b111;
   logic [9:0]  rdi [3] = '{3{10'd0}};
   logic [31:0] d1 [3];
   logic [31:0] d2 [3];

   always @(posedge clk) begin
      for (int k = 0; k < 3; k++) begin
         if (rd_en_v[k]) rdi[k] <= rdi[k] + 10'd1;
         d1[k] <= store[k][rdi[k]];
         d2[k] <= d1[k];
      end
   end

   assign empty_v[0] = force_empty[0] || (rdi[0] >= fill[0]);
   assign empty_v[1] = force_empty[1] || (rdi[1] >= fill[1]);
   assign empty_v[2] = force_empty[2] || (rdi[2] >= fill[2]);
   assign rdata0 = store[0][rdi[0]];
   assign rdata1 = d1[1];
   assign rdata2 = d2[2];

   fifo_rd2axis #(.DWIDTH(32), .RD_LATENCY(0), .PKT_LEN(0)) u0 (
      .clk(clk), .rst(rst_v[0]), .fifo_rd_data(rdata0), .fifo_empty(empty_v[0]),
      .fifo_rd_en(rd_en_v[0]), .m_axis_tdata(tdata0), .m_axis_tvalid(tvalid_v[0]),
      .m_axis_tready(tready_v[0]), .m_axis_tlast(tlast_v[0]), .level(level0));

   fifo_rd2axis #(.DWIDTH(32), .RD_LATENCY(1), .PKT_LEN(4)) u1 (
      .clk(clk), .rst(rst_v[1]), .fifo_rd_data(rdata1), .fifo_empty(empty_v[1]),
      .fifo_rd_en(rd_en_v[1]), .m_axis_tdata(tdata1), .m_axis_tvalid(tvalid_v[1]),
      .m_axis_tready(tready_v[1]), .m_axis_tlast(tlast_v[1]), .level(level1));

   fifo_rd2axis #(.DWIDTH(32), .RD_LATENCY(2), .PKT_LEN(0)) u2 (
      .clk(clk), .rst(rst_v[2]), .fifo_rd_data(rdata2), .fifo_empty(empty_v[2]),
      .fifo_rd_en(rd_en_v[2]), .m_axis_tdata(tdata2), .m_axis_tvalid(tvalid_v[2]),
      .m_axis_tready(tready_v[2]), .m_axis_tlast(tlast_v[2]), .level(level2));

   function automatic logic [31:0] tdata_of(input int k);
      case (k)
         0:       return tdata0;
         1:       return tdata1;
         default: return tdata2;
      endcase
   endfunction

   function automatic int level_of(input int k);
      case (k)
         0:       return int'(level0);
         1:       return int'(level1);
         default: return int'(level2);
      endcase
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Put n words into FIFO k behind its current read position.
   task automatic load(input int k, input int n, input bit rnd);
      for (int i = 0; i < n; i++)
         store[k][rdi[k] + 10'(i)] = rnd ? $urandom : 32'(i);
      fill[k] = rdi[k] + 10'(n);
   endtask

   // Reset instance k together with its FIFO (remaining words are dropped).
   task automatic do_reset(input int k);
      rst_v[k] = 1'b0;
      tready_v[k] = 1'b0;
      force_empty[k] = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      fill[k] = rdi[k];
      rst_v[k] = 1'b1;
   endtask

   task automatic test_reset();
      rst_v = 3'b000;
      tready_v = 3'b111;
      for (int k = 0; k < 3; k++) load(k, 4, 1'b0);
      force_empty = 3'b000;
      repeat (2) @(posedge clk);
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
         n_tests++;
         if (rd_en_v[k] !== 1'b0) begin n_fail++; $display("FAIL reset_rd_en[%0d]: got %b want 0", k, rd_en_v[k]); end
         n_tests++;
         if (tvalid_v[k] !== 1'b0) begin n_fail++; $display("FAIL reset_tvalid[%0d]: got %b want 0", k, tvalid_v[k]); end
         n_tests++;
         if (tlast_v[k] !== 1'b0) begin n_fail++; $display("FAIL reset_tlast[%0d]: got %b want 0", k, tlast_v[k]); end
         n_tests++;
         if (tdata_of(k) !== 32'd0) begin n_fail++; $display("FAIL reset_tdata[%0d]: got %h want 0", k, tdata_of(k)); end
         n_tests++;
         if (level_of(k) != 0) begin n_fail++; $display("FAIL reset_level[%0d]: got %0d want 0", k, level_of(k)); end
      end
      step();
      force_empty = 3'b111;
      for (int k = 0; k < 3; k++) fill[k] = rdi[k];
      rst_v = 3'b111;
      tready_v = 3'b000;
   endtask

   // Latency 1, 100 words, tready held high: pops in cycles 0..99, beats in 2..101.
   task automatic test_streaming();
      logic exp_en, exp_v;
      do_reset(1);
      load(1, 100, 1'b0);
      force_empty[1] = 1'b0;
      tready_v[1] = 1'b1;
      for (int c = 0; c < 105; c++) begin
         @(negedge clk);
         exp_en = (c < 100);
         exp_v  = (c >= 2) && (c < 102);
         n_tests++;
         if (rd_en_v[1] !== exp_en) begin n_fail++; $display("FAIL stream_rd_en c=%0d: got %b want %b", c, rd_en_v[1], exp_en); end
         n_tests++;
         if (tvalid_v[1] !== exp_v) begin n_fail++; $display("FAIL stream_tvalid c=%0d: got %b want %b", c, tvalid_v[1], exp_v); end
         if (exp_v) begin
            n_tests++;
            if (tdata1 !== 32'(c - 2)) begin n_fail++; $display("FAIL stream_tdata c=%0d: got %0d want %0d", c, tdata1, c - 2); end
         end
         step();
      end
   endtask

   // Packet length 4, 12 beats, with beat 3 stalled for three cycles.
   task automatic test_tlast();
      int beats = 0, stall = 0, nlast = 0;
      logic exp_last;
      do_reset(1);
      load(1, 12, 1'b0);
      force_empty[1] = 1'b0;
      for (int c = 0; c < 60 && beats < 12; c++) begin
         tready_v[1] = !(beats == 3 && stall < 3);
         @(negedge clk);
         if (tvalid_v[1]) begin
            exp_last = (beats % 4 == 3);
            n_tests++;
            if (tdata1 !== 32'(beats)) begin n_fail++; $display("FAIL tlast_tdata beat=%0d: got %0d want %0d", beats, tdata1, beats); end
            n_tests++;
            if (tlast_v[1] !== exp_last) begin n_fail++; $display("FAIL tlast_flag beat=%0d: got %b want %b", beats, tlast_v[1], exp_last); end
            if (tready_v[1]) begin
               if (tlast_v[1]) nlast++;
               beats++;
            end else stall++;
         end else begin
            n_tests++;
            if (tlast_v[1] !== 1'b0) begin n_fail++; $display("FAIL tlast_idle: got %b want 0", tlast_v[1]); end
         end
         step();
      end
      n_tests++;
      if (beats != 12) begin n_fail++; $display("FAIL tlast_beats: got %0d want 12", beats); end
      n_tests++;
      if (stall != 3) begin n_fail++; $display("FAIL tlast_stall_cycles: got %0d want 3", stall); end
      n_tests++;
      if (nlast != 3) begin n_fail++; $display("FAIL tlast_count: got %0d want 3", nlast); end
   endtask

   // Latency 2 with tready low: exactly 4 pops, then drain in order.
   task automatic test_backpressure();
      int pops = 0, beats = 0, extra = 0;
      do_reset(2);
      load(2, 20, 1'b0);
      force_empty[2] = 1'b0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         if (rd_en_v[2]) pops++;
         step();
      end
      @(negedge clk);
      n_tests++;
      if (pops != 4) begin n_fail++; $display("FAIL bp_pops: got %0d want 4", pops); end
      n_tests++;
      if (level2 !== 3'd4) begin n_fail++; $display("FAIL bp_level: got %0d want 4", level2); end
      n_tests++;
      if (rd_en_v[2] !== 1'b0) begin n_fail++; $display("FAIL bp_rd_en: got %b want 0", rd_en_v[2]); end
      n_tests++;
      if (tdata2 !== 32'd0) begin n_fail++; $display("FAIL bp_head: got %0d want 0", tdata2); end
      step();
      tready_v[2] = 1'b1;
      for (int c = 0; c < 60; c++) begin
         @(negedge clk);
         if (tvalid_v[2]) begin
            if (beats >= 20) extra++;
            else begin
               n_tests++;
               if (tdata2 !== 32'(beats)) begin n_fail++; $display("FAIL bp_order beat=%0d: got %0d want %0d", beats, tdata2, beats); end
            end
            beats++;
         end
         step();
      end
      n_tests++;
      if (beats != 20) begin n_fail++; $display("FAIL bp_beats: got %0d want 20", beats); end
      n_tests++;
      if (extra != 0) begin n_fail++; $display("FAIL bp_duplicates: got %0d want 0", extra); end
   endtask

   // FIFO reports empty; a single non-empty cycle must give exactly one beat.
   task automatic test_empty();
      int beats = 0;
      do_reset(2);
      load(2, 5, 1'b0);
      tready_v[2] = 1'b1;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         n_tests++;
         if (rd_en_v[2] !== 1'b0) begin n_fail++; $display("FAIL empty_rd_en c=%0d: got %b want 0", c, rd_en_v[2]); end
         n_tests++;
         if (tvalid_v[2] !== 1'b0) begin n_fail++; $display("FAIL empty_tvalid c=%0d: got %b want 0", c, tvalid_v[2]); end
         step();
      end
      force_empty[2] = 1'b0;
      @(negedge clk);
      n_tests++;
      if (rd_en_v[2] !== 1'b1) begin n_fail++; $display("FAIL empty_single_pop: got %b want 1", rd_en_v[2]); end
      step();
      force_empty[2] = 1'b1;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         if (tvalid_v[2]) begin
            n_tests++;
            if (tdata2 !== 32'd0) begin n_fail++; $display("FAIL empty_tdata: got %0d want 0", tdata2); end
            beats++;
         end
         step();
      end
      n_tests++;
      if (beats != 1) begin n_fail++; $display("FAIL empty_beats: got %0d want 1", beats); end
   endtask

   // Latency 0 with random tready and random empty: in-order scoreboard.
   task automatic test_random();
      int beats = 0;
      logic [9:0] base;
      logic prev_stall = 1'b0;
      logic [31:0] prev_data = '0;
      do_reset(0);
      base = rdi[0];
      load(0, 200, 1'b1);
      for (int c = 0; c < 600; c++) begin
         tready_v[0] = (c >= 500) ? 1'b1 : 1'($urandom % 2);
         force_empty[0] = (c >= 500) ? 1'b0 : ($urandom % 4 == 0);
         @(negedge clk);
         n_tests++;
         if (level0 > 2'd2) begin n_fail++; $display("FAIL rnd_level c=%0d: got %0d want <=2", c, level0); end
         n_tests++;
         if (rd_en_v[0] && empty_v[0]) begin n_fail++; $display("FAIL rnd_pop_empty c=%0d: got rd_en=1 want 0", c); end
         if (prev_stall) begin
            n_tests++;
            if (tvalid_v[0] !== 1'b1 || tdata0 !== prev_data) begin
               n_fail++; $display("FAIL rnd_stable c=%0d: got v=%b d=%h want v=1 d=%h", c, tvalid_v[0], tdata0, prev_data);
            end
         end
         if (tvalid_v[0] && tready_v[0]) begin
            n_tests++;
            if (tdata0 !== store[0][base + 10'(beats)]) begin
               n_fail++; $display("FAIL rnd_data beat=%0d: got %h want %h", beats, tdata0, store[0][base + 10'(beats)]);
            end
            beats++;
         end
         prev_stall = tvalid_v[0] && !tready_v[0];
         prev_data = tdata0;
         step();
      end
      n_tests++;
      if (beats != 200) begin n_fail++; $display("FAIL rnd_beats: got %0d want 200", beats); end
      n_tests++;
      if (rdi[0] - base != 10'd200) begin n_fail++; $display("FAIL rnd_pops: got %0d want 200", rdi[0] - base); end
   endtask

   // Latency 2: reset while occ=3 and one pop is in flight; nothing may emerge.
   task automatic test_reset_midstream();
      do_reset(2);
      load(2, 20, 1'b0);
      force_empty[2] = 1'b0;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         step();
      end
      rst_v[2] = 1'b0;
      @(negedge clk);
      n_tests++;
      if (level2 !== 3'd3) begin n_fail++; $display("FAIL mid_pre_level: got %0d want 3", level2); end
      step();
      rst_v[2] = 1'b1;
      fill[2] = rdi[2];
      force_empty[2] = 1'b1;
      tready_v[2] = 1'b1;
      @(negedge clk);
      n_tests++;
      if (level2 !== 3'd0) begin n_fail++; $display("FAIL mid_level: got %0d want 0", level2); end
      n_tests++;
      if (tlast_v[2] !== 1'b0) begin n_fail++; $display("FAIL mid_tlast: got %b want 0", tlast_v[2]); end
      for (int c = 0; c < 8; c++) begin
         n_tests++;
         if (tvalid_v[2] !== 1'b0) begin n_fail++; $display("FAIL mid_tvalid c=%0d: got %b want 0", c, tvalid_v[2]); end
         step();
         @(negedge clk);
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_streaming();
      test_tlast();
      test_backpressure();
      test_empty();
      test_random();
      test_reset_midstream();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/fifo_rd2axis.md
Name: fifo_rd2axis

Overview:
- Read-side adapter on the rd_clk domain, directly downstream of the async/sync FIFO read port.
- Drives the FIFO pop strobe under credit control and absorbs the FIFO's read latency in a small skid buffer.
- Presents an AXI-Stream master with full 1 beat/cycle throughput.
- Optionally generates tlast every PKT_LEN beats for packetised consumers.

Parameters:
- DWIDTH, 32: data width; must match the FIFO DWIDTH.
- RD_LATENCY, 1: cycles from the pop cycle to fifo_rd_data being valid. 0 means FWFT/combinational; legal range 0..2.
- PKT_LEN, 0: beats per packet for tlast generation. 0 disables tlast (held 0).
- BUF_DEPTH, derived localparam = RD_LATENCY+2: skid buffer entries.

Ports:
- clk  in  1  single clock (FIFO rd_clk).
- rst  in  1  synchronous, active-low reset: rst==0 at a clk edge resets the block.
- fifo_rd_data  in  DWIDTH  FIFO read data; valid RD_LATENCY cycles after a pop.
- fifo_empty  in  1  FIFO empty status in the current cycle.
- fifo_rd_en  out  1  pop strobe; a pop occurs on each cycle it is high.
- m_axis_tdata  out  DWIDTH  head-of-buffer data.
- m_axis_tvalid  out  1  buffer non-empty.
- m_axis_tready  in  1  downstream accept.
- m_axis_tlast  out  1  last beat of packet.
- level  out  $clog2(BUF_DEPTH+1)  skid buffer occupancy (registered).

Behaviour:
- Reset (rst==0 at edge):
  - Buffer pointers, occ, in-flight pipe and beat counter cleared.
  - fifo_rd_en forced 0 combinationally while rst==0.
  - tvalid=0, tlast=0, level=0, tdata=0.
- Reset mid-operation: in-flight pops and buffered beats are discarded, with no beat emitted afterwards. The FIFO must be reset alongside this block.
- Pop rule: fifo_rd_en = rst && !fifo_empty && (occ + inflight < BUF_DEPTH).
  - inflight = count of pops whose data is not yet written (0..RD_LATENCY).
  - fifo_rd_en never asserts while fifo_empty==1.
- In-flight pipe:
  - 1-bit valid shift register of length RD_LATENCY.
  - At the end of cycle t+RD_LATENCY, fifo_rd_data is written into the buffer for a pop issued in cycle t. With RD_LATENCY=0 the write happens at the end of the pop cycle.
- Latency: a pop in cycle t gives tvalid=1 in cycle t+RD_LATENCY+1. There is no combinational bypass of the buffer.
- Output handshake:
  - tvalid = (occ!=0); tdata = buffer[rd_ptr].
  - A beat transfers when tvalid && tready; rd_ptr then advances mod BUF_DEPTH.
  - While tvalid=1 and tready=0, tdata and tlast are held stable.
- Simultaneous write and transfer: occ unchanged, both pointers advance.
- Wrap-around: pointers wrap mod BUF_DEPTH; BUF_DEPTH need not be a power of 2.
- Overflow: the credit rule guarantees no write when occ==BUF_DEPTH. A simulation assertion fires if violated.
- Throughput: with tready=1 and the FIFO never empty, fifo_rd_en stays 1 and one beat per cycle is sustained. In steady state occ+inflight = RD_LATENCY+1.
- Backpressure: with tready=0, pops stop once occ+inflight reaches BUF_DEPTH; no data is lost.
- tlast:
  - PKT_LEN>0: beat_cnt counts transfers 0..PKT_LEN-1 and wraps to 0 after the transfer at PKT_LEN-1. tlast = tvalid && (beat_cnt==PKT_LEN-1).
  - PKT_LEN==1: tlast = tvalid.
  - PKT_LEN==0: tlast = 0.
- level: registered occ. It does not include in-flight pops.

Decomposition:
- easy_fifo_pkg holds:
  - RD_LATENCY_MAX=2.
  - Function ptr_inc(ptr, depth) for non-power-of-2 wrap.
  - Width helper for level/beat_cnt.
- One sub-module, fifo_rd2axis_buf: BUF_DEPTH-entry register circular buffer with wr/rd strobes, occ, head data, and the overflow assertion.
- Credit logic, in-flight pipe and tlast counter stay in the top.

Test Plan:
- Streaming: RD_LATENCY=1, FIFO preloaded with 0..99, tready=1.
  - First pop at cycle 0; tvalid at cycle 2.
  - Beats 0..99 arrive on consecutive cycles in order.
  - fifo_rd_en stays high for 100 cycles.
- Backpressure: RD_LATENCY=2, tready=0 from start.
  - Exactly 4 pops issued; level settles at 4; fifo_rd_en then 0.
  - Raising tready yields beats in order with no loss or duplication.
- Empty FIFO: fifo_empty=1 throughout.
  - fifo_rd_en=0 and tvalid=0 for all cycles.
  - Deasserting empty for one cycle yields exactly one beat.
- Random mix: RD_LATENCY=0, random tready (50%) and random fifo_empty.
  - Scoreboard shows every popped word emitted once, in order.
  - tdata stable while stalled; level never exceeds 2.
- tlast: PKT_LEN=4, 12 beats → tlast on beats 3, 7, 11. A stall on beat 3 holds tlast=1 until transfer.
- Reset mid-stream: rst=0 for one cycle with occ=3 and 1 pop in flight.
  - Next cycle: tvalid=0, level=0, tlast=0, beat_cnt=0.
  - The in-flight word is never emitted.
